// File: rtl/alu32_pkg.sv
// alu32_pkg: shared state encodings and ALU select constants for the alu32 issue controller
package alu32_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, RESP = 2'd3} state_t;
  localparam logic [1:0] SEL_SHIFT = 2'b00;
  localparam logic [1:0] SEL_ADD_A = 2'b01;
  localparam logic [1:0] SEL_ADD_B = 2'b10;
  localparam logic [1:0] SEL_LOGIC = 2'b11;
  localparam int SUB_BIT = 4;
  function automatic logic is_add(input logic [4:0] ctrl);
    return ctrl[1:0] == SEL_ADD_A || ctrl[1:0] == SEL_ADD_B;
  endfunction
endpackage

// File: rtl/alu_operand_swap.sv
// alu_operand_swap: pre-swaps operand halves so the ALU adder's crossed inputs see A and B intact
module alu_operand_swap (
  input  logic        i_en,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_x,
  output logic [31:0] o_y
);
  assign o_x = i_en ? {i_y[31:16], i_x[15:0]} : i_x;
  assign o_y = i_en ? {i_x[31:16], i_y[15:0]} : i_y;
endmodule

// File: rtl/alu32_sequencer.sv
// alu32_sequencer: issues one op at a time to alu32, chaining carry across two passes for 64-bit add/sub
module alu32_sequencer
  import alu32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_ctrl,
  input  logic             req_wide,
  input  logic             req_cin,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] op_count,
  output logic [31:0]      alu_x,
  output logic [31:0]      alu_y,
  output logic [4:0]       alu_control,
  output logic             alu_cin,
  input  logic [31:0]      alu_out,
  input  logic             alu_cout
);
  state_t           r_state, w_next;
  logic [4:0]       r_ctrl;
  logic             r_wide, r_cin, r_carry_lo, r_carry;
  logic [63:0]      r_a, r_b, r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             w_add, w_hi, w_act;
  logic [31:0]      w_x, w_y;
  assign w_add = is_add(r_ctrl);
  assign w_hi  = r_state == HI;
  assign w_act = r_state == LO || w_hi;
  alu_operand_swap u_swap (
    .i_en (w_add),
    .i_x  (w_hi ? r_a[63:32] : r_a[31:0]),
    .i_y  (w_hi ? r_b[63:32] : r_b[31:0]),
    .o_x  (w_x),
    .o_y  (w_y)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (req_valid ? LO : IDLE) :
             r_state == LO   ? (r_wide ? HI : RESP) :
             r_state == HI   ? RESP :
             (rsp_ready ? IDLE : RESP);
    req_ready   = r_state == IDLE;
    rsp_valid   = r_state == RESP;
    alu_x       = w_act ? w_x : '0;
    alu_y       = w_act ? w_y : '0;
    alu_control = w_act ? r_ctrl : '0;
    alu_cin     = r_state == LO ? r_cin : w_hi ? r_carry_lo : 1'b0;
  end
  // Upper result half is cleared on accept so narrow ops return zero there
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_wide     <= 1'b0;
      r_cin      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_carry_lo <= 1'b0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
    end else
      case (r_state)
        IDLE: if (req_valid) begin
          r_ctrl  <= req_ctrl;
          r_wide  <= req_wide && is_add(req_ctrl);
          r_cin   <= req_cin;
          r_a     <= req_a;
          r_b     <= req_b;
          r_res   <= '0;
          r_carry <= 1'b0;
        end
        LO: begin
          r_res[31:0] <= alu_out;
          r_carry_lo  <= alu_cout;
          r_carry     <= w_add && alu_cout;
        end
        HI: begin
          r_res[63:32] <= alu_out;
          r_carry      <= alu_cout;
        end
        RESP: if (rsp_ready) r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
        default: ;
      endcase
  assign rsp_data  = r_res;
  assign rsp_carry = r_carry;
  assign op_count  = r_cnt;
endmodule

// File: tb/tb_alu32_sequencer.sv
// tb_alu32_sequencer: directed checks of alu32_sequencer against a behavioural alu32 model
module tb_alu32_sequencer;
  import alu32_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_wide = 1'b0, req_cin = 1'b0, rsp_ready = 1'b0;
  logic [4:0]  req_ctrl = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, rsp_carry, alu_cin, alu_cout;
  logic [63:0] rsp_data;
  logic [15:0] op_count;
  logic [31:0] alu_x, alu_y, alu_out;
  logic [4:0]  alu_control;
  logic        d2_req_ready, d2_rsp_valid, d2_rsp_carry, d2_alu_cin;
  logic [63:0] d2_rsp_data;
  logic [1:0]  d2_op_count;
  logic [31:0] d2_alu_x, d2_alu_y;
  logic [4:0]  d2_alu_control;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu32_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_wide(req_wide), .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .op_count(op_count), .alu_x(alu_x), .alu_y(alu_y), .alu_control(alu_control),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
  );
  // Narrow-counter twin sees identical stimulus, so its ALU inputs match the main instance
  alu32_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(d2_req_ready),
    .req_ctrl(req_ctrl), .req_wide(req_wide), .req_cin(req_cin), .req_a(req_a), .req_b(req_b),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d2_rsp_data), .rsp_carry(d2_rsp_carry),
    .op_count(d2_op_count), .alu_x(d2_alu_x), .alu_y(d2_alu_y), .alu_control(d2_alu_control),
    .alu_cin(d2_alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
  );
  logic [31:0] m_a, m_b;
  logic [32:0] m_sum;
  always_comb begin
    m_a   = {alu_y[31:16], alu_x[15:0]};
    m_b   = {alu_x[31:16], alu_y[15:0]};
    m_sum = {1'b0, m_a} + {1'b0, alu_control[SUB_BIT] ? ~m_b : m_b} + {32'd0, alu_cin};
    alu_out  = alu_x << alu_y[4:0];
    alu_cout = 1'b1;
    if (alu_control[1:0] == SEL_ADD_A || alu_control[1:0] == SEL_ADD_B) begin
      alu_out  = m_sum[31:0];
      alu_cout = m_sum[32];
    end else if (alu_control[1:0] == SEL_LOGIC) alu_out = alu_x ^ alu_y;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] c, input logic w, input logic ci, input logic [63:0] a, input logic [63:0] b);
    req_ctrl = c; req_wide = w; req_cin = ci; req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask
  task automatic finish_op();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_control), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    #11 rst_n = 1'b1;
    step();
    issue(5'b00001, 1'b0, 1'b0, 64'h3, 64'h5);
    chk("add_lo_x", 64'(alu_x), 64'h3);
    chk("add_lo_y", 64'(alu_y), 64'h5);
    chk("add_lo_ctrl", 64'(alu_control), 64'h01);
    chk("add_lo_valid", 64'(rsp_valid), 64'd0);
    chk("add_lo_ready", 64'(req_ready), 64'd0);
    step();
    chk("add_valid", 64'(rsp_valid), 64'd1);
    chk("add_data", rsp_data, 64'h8);
    chk("add_carry", 64'(rsp_carry), 64'd0);
    chk("add_ctrl_resp", 64'(alu_control), 64'd0);
    finish_op();
    chk("add_count", 64'(op_count), 64'd1);
    chk("add_count2", 64'(d2_op_count), 64'd1);
    chk("add_idle_ready", 64'(req_ready), 64'd1);
    issue(5'b10001, 1'b0, 1'b1, 64'h0001_0000, 64'h1);
    chk("sub_lo_x", 64'(alu_x), 64'h0);
    chk("sub_lo_y", 64'(alu_y), 64'h0001_0001);
    chk("sub_lo_cin", 64'(alu_cin), 64'd1);
    step();
    chk("sub_data", rsp_data, 64'h0000_0000_0000_FFFF);
    chk("sub_carry", 64'(rsp_carry), 64'd1);
    finish_op();
    issue(5'b00001, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001);
    chk("wide_lo_cin", 64'(alu_cin), 64'd0);
    step();
    chk("wide_hi_valid", 64'(rsp_valid), 64'd0);
    chk("wide_hi_cin", 64'(alu_cin), 64'd1);
    step();
    chk("wide_valid", 64'(rsp_valid), 64'd1);
    chk("wide_data", rsp_data, 64'h0000_0001_0000_0000);
    chk("wide_carry", 64'(rsp_carry), 64'd0);
    finish_op();
    issue(5'b00001, 1'b1, 1'b0, 64'hAAAA_5555_0000_0000, 64'h1111_2222_0000_0000);
    step();
    chk("wide2_hi_x", 64'(alu_x), 64'h1111_5555);
    chk("wide2_hi_y", 64'(alu_y), 64'hAAAA_2222);
    chk("wide2_hi_cin", 64'(alu_cin), 64'd0);
    step();
    chk("wide2_data", rsp_data, 64'hBBBB_7777_0000_0000);
    finish_op();
    issue(5'b00111, 1'b1, 1'b0, 64'hDEAD_BEEF_F0F0_F0F0, 64'h1234_5678_0F0F_00FF);
    chk("logic_lo_x", 64'(alu_x), 64'hF0F0_F0F0);
    chk("logic_lo_y", 64'(alu_y), 64'h0F0F_00FF);
    step();
    chk("logic_valid", 64'(rsp_valid), 64'd1);
    chk("logic_data", rsp_data, 64'h0000_0000_FFFF_F00F);
    chk("logic_carry", 64'(rsp_carry), 64'd0);
    finish_op();
    chk("logic_count", 64'(op_count), 64'd5);
    issue(5'b00010, 1'b0, 1'b0, 64'h7, 64'h9);
    step();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", rsp_data, 64'h10);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_count", 64'(op_count), 64'd5);
      step();
    end
    req_valid = 1'b0;
    finish_op();
    chk("bp_count_inc", 64'(op_count), 64'd6);
    chk("sat_count2", 64'(d2_op_count), 64'd3);
    chk("bp_idle", 64'(rsp_valid), 64'd0);
    issue(5'b00001, 1'b1, 1'b0, 64'hAAAA_5555_0000_0000, 64'h1111_2222_0000_0000);
    step();
    chk("rst_pre_x", 64'(alu_x), 64'h1111_5555);
    rst_n = 1'b0;
    #1;
    chk("rstmid_x", 64'(alu_x), 64'd0);
    chk("rstmid_ctrl", 64'(alu_control), 64'd0);
    chk("rstmid_count", 64'(op_count), 64'd0);
    chk("rstmid_count2", 64'(d2_op_count), 64'd0);
    chk("rstmid_ready", 64'(req_ready), 64'd1);
    chk("rstmid_data", rsp_data, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_count", 64'(op_count), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alu32_sequencer.md
Name: alu32_sequencer

Overview:
- Issue controller for the combinational alu32 datapath.
- Accepts one operation at a time from a valid/ready requester and drives the ALU's x, y, control and carry-in.
- Sequences 64-bit add/sub as two 32-bit passes with the carry chained between them.
- Returns the registered result on a valid/ready response port and keeps a saturating completed-op counter.

Parameters:
- CNT_W, 16, width of the completed-operation counter (saturating)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_ctrl  in  5  ALU control word, passed unchanged to the ALU
- req_wide  in  1  64-bit operation; honoured only for adder ops
- req_cin  in  1  carry-in for the first (low) pass
- req_a  in  64  operand A (narrow ops use [31:0])
- req_b  in  64  operand B (narrow ops use [31:0])
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  64  result; upper 32 bits are zero for narrow ops
- rsp_carry  out  1  adder carry-out of the final pass; 0 for non-adder ops
- op_count  out  CNT_W  completed responses, saturating
- alu_x  out  32  to ALU Input_x
- alu_y  out  32  to ALU Input_y
- alu_control  out  5  to ALU Input_control
- alu_cin  out  1  to ALU Input_cin
- alu_out  in  32  from ALU monitor_out
- alu_cout  in  1  from ALU monitor_overflow

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - All outputs are 0, except req_ready = 1 once in IDLE.
  - Captured operands, result and op_count are 0.
  - Reset mid-operation abandons the op; no response is produced.
- Adder ops: req_ctrl[1:0] = 01 or 10. The ALU adder computes a + b (ctrl[4] = 0) or a + ~b + cin (ctrl[4] = 1), where its a and b are formed as a = {Input_y[31:16], Input_x[15:0]} and b = {Input_x[31:16], Input_y[15:0]}.
  - For adder ops the sequencer pre-swaps the operand halves: alu_x = {B[31:16], A[15:0]}, alu_y = {A[31:16], B[15:0]}. The ALU then sees a = A, b = B exactly.
  - Non-adder ops drive alu_x = A and alu_y = B unswapped.
- req_wide with a non-adder op is treated as narrow.
- State machine:
  - IDLE:
    - req_ready = 1.
    - On req_valid, capture ctrl, wide_eff, cin, a, b; go to LO.
  - LO:
    - Drive the low 32-bit halves, alu_control = ctrl, alu_cin = cin.
    - At the clock edge, capture alu_out into res[31:0] and alu_cout into carry_lo.
    - Next state is HI if wide_eff, else RESP.
  - HI:
    - Drive the high halves (swapped per the adder rule), alu_cin = carry_lo.
    - At the clock edge, capture res[63:32] and the final carry.
    - Next state is RESP.
  - RESP:
    - rsp_valid = 1 and rsp_data/rsp_carry are held stable while rsp_ready = 0.
    - On rsp_ready: op_count increments (holds at all-ones), then go to IDLE.
- ALU outputs are driven from registered state only, so there is no combinational path from req_* to alu_*.
- Latency from accept edge to rsp_valid: 2 cycles narrow, 3 cycles wide. Throughput is one op per 3 or 4 cycles when rsp_ready is held high.
- req_ready = 0 outside IDLE; req_valid is ignored then.
- alu_control and alu_cin are 0 in IDLE and RESP.
- Narrow ops:
  - rsp_data[63:32] = 0.
  - rsp_carry = carry_lo for adder ops, 0 otherwise.

Decomposition:
- Shared package/header alu32_pkg:
  - State encodings IDLE = 0, LO = 1, HI = 2, RESP = 3.
  - ALU mux-select constants SEL_SHIFT = 00, SEL_ADD = 01/10, SEL_LOGIC = 11.
  - SUB bit position (4).
- One sub-module, alu_operand_swap: combinational half-swap of a 32-bit operand pair, enabled by the adder select.

Test Plan:
1. Narrow ADD: ctrl = 0_00_01, A = 0x00000003, B = 0x00000005, cin = 0 -> rsp_valid 2 cycles after accept; rsp_data = 0x0000000000000008, rsp_carry = 0.
2. Narrow SUB, checks the swap: ctrl = 1_00_01, A = 0x00010000, B = 0x00000001, cin = 1 -> rsp_data = 0x000000000000FFFF, rsp_carry = 1. During LO, alu_x = 0x00000000 and alu_y = 0x00010001.
3. Wide ADD carry chain: A = 0x00000000_FFFFFFFF, B = 0x00000000_00000001, cin = 0 -> LO carry 1; HI alu_cin = 1; rsp_data = 0x00000001_00000000, rsp_carry = 0, 3-cycle latency.
4. Logic op with req_wide = 1: ctrl = 0_01_11 -> treated as narrow; alu_x = A, alu_y = B unswapped; rsp_data[63:32] = 0, rsp_carry = 0.
5. Backpressure and counter:
   - Hold rsp_ready = 0 for 5 cycles -> rsp_data stable, req_ready = 0, op_count unchanged.
   - Release -> op_count += 1.
   - Preload to 0xFFFF and complete one op -> stays 0xFFFF.
6. Reset mid-op: assert rst_n = 0 during HI -> outputs 0 immediately; after release req_ready = 1, no rsp_valid, op_count = 0.
